// File: rtl/t_flip_flop_pkg.sv
// t_flip_flop_pkg: shared constants and types for the toggle flip-flop bank.
package t_flip_flop_pkg;

  // A single toggle bit is the default so the bank drops in as one T flip-flop.
  localparam int TFF_DEFAULT_WIDTH = 1;

  // Every bit resets to zero unless the instantiating block overrides it.
  localparam logic TFF_DEFAULT_RESET_BIT = 1'b0;

  // Toggle-request vector at the default width.
  typedef logic [TFF_DEFAULT_WIDTH-1:0] toggle_vec_t;

endpackage

// File: rtl/t_flip_flop_tff_cell.sv
// tff_cell: one toggle bit with async active-low reset, optional sync load,
// and toggle. Priority is reset, then load, then toggle.
module tff_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic t,
  input  logic load,
  input  logic d,
  output logic q
);

  // Reset forces the stored bit immediately; otherwise load wins over toggle.
  // XOR with t keeps an unknown toggle request visible as an unknown state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_BIT;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/t_flip_flop.sv
// t_flip_flop: parameterised bank of independent toggle flip-flops.
// Define T_FLIP_FLOP_LOAD_EN to add the load/D synchronous parallel-load ports;
// without it the block is a pure toggle bank.
module t_flip_flop
  import t_flip_flop_pkg::*;
#(
  parameter int               WIDTH     = TFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{TFF_DEFAULT_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] T,
`ifdef T_FLIP_FLOP_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] D,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n
);

  logic             loadEn;
  logic [WIDTH-1:0] loadData;

  // Route the parallel-load inputs to the cells, or hold them inactive when
  // the load feature is compiled out.
`ifdef T_FLIP_FLOP_LOAD_EN
  assign loadEn   = load;
  assign loadData = D;
`else
  assign loadEn   = 1'b0;
  assign loadData = '0;
`endif

  // One cell per bit; bits never interact, so there is no carry between them.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell #(
      .RESET_BIT(RESET_VAL[i])
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .t    (T[i]),
      .load (loadEn),
      .d    (loadData[i]),
      .q    (Q[i])
    );
  end

  // The complement output is derived from Q so it can never drift from it.
  assign Q_n = ~Q;

endmodule

// File: tb/tb_t_flip_flop.sv
// tb_t_flip_flop: randomized scoreboard bench for a 4-bit toggle bank with a
// non-zero reset value. Stimulus pushes expected Q values; a monitor pops them.
module tb_t_flip_flop;

  localparam int             W  = 4;
  localparam logic [W-1:0]   RV = 4'b1010;
`ifdef T_FLIP_FLOP_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [W-1:0] T;
  logic [W-1:0] Q;
  logic [W-1:0] Q_n;
`ifdef T_FLIP_FLOP_LOAD_EN
  logic         load;
  logic [W-1:0] D;
`endif

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] expQ[$];
  logic [W-1:0] model;

  t_flip_flop #(
    .WIDTH    (W),
    .RESET_VAL(RV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .T    (T),
`ifdef T_FLIP_FLOP_LOAD_EN
    .load (load),
    .D    (D),
`endif
    .Q    (Q),
    .Q_n  (Q_n)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b required %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge and record the state the
  // bank must hold after the next rising edge.
  task automatic applyStimulus(input logic [W-1:0] t, input logic ld, input logic [W-1:0] d);
    @(negedge clk);
    T = t;
`ifdef T_FLIP_FLOP_LOAD_EN
    load = ld;
    D    = d;
`endif
    if (LOAD_EN && ld) model = d;
    else               model = model ^ t;
    expQ.push_back(model);
  endtask

  // Assert reset between edges, check the immediate return to the reset value,
  // hold it across a rising edge with random toggles, then release.
  task automatic midReset();
    @(negedge clk);
    #1 reset = 1'b0;
    T = W'($urandom);
    #1;
    checkOutput("async_reset_q", Q, RV);
    checkOutput("async_reset_qn", Q_n, ~RV);
    model = RV;
    @(negedge clk);
    checkOutput("reset_hold_q", Q, RV);
    reset = 1'b1;
    T = '0;
  endtask

  // Monitor: one sample per rising edge, compared against the queued model.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("q", Q, e);
        checkOutput("q_n", Q_n, ~e);
      end
    end
  end

  initial begin
    reset = 1'b0;
    T     = '0;
`ifdef T_FLIP_FLOP_LOAD_EN
    load  = 1'b0;
    D     = '0;
`endif
    model = RV;

    // Reset held with T low, then with T high across edges: no toggles.
    #10;
    checkOutput("reset_q", Q, RV);
    checkOutput("reset_qn", Q_n, ~RV);
    T = '1;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("reset_t1_q", Q, RV);
    checkOutput("reset_t1_qn", Q_n, ~RV);

    // Release between edges.
    @(negedge clk);
    reset = 1'b1;
    T     = '0;

    // Hold, selective toggle, hold, clk/2 square wave, hold.
    applyStimulus(4'b0000, 1'b0, '0);
    applyStimulus(4'b0000, 1'b0, '0);
    applyStimulus(4'b0110, 1'b0, '0);
    applyStimulus(4'b0000, 1'b0, '0);
    for (int i = 0; i < 4; i++) applyStimulus(4'b1111, 1'b0, '0);
    applyStimulus(4'b0000, 1'b0, '0);
    applyStimulus(4'b0000, 1'b0, '0);

    // Mid-run reset then resume toggling from the reset value.
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 1'b0, '0);
    midReset();
    applyStimulus(4'b1111, 1'b0, '0);

    // Parallel load beats toggle; next edge toggles from the loaded value.
    if (LOAD_EN) begin
      applyStimulus(4'b0000, 1'b1, 4'b0011);
      applyStimulus(4'b1111, 1'b1, 4'b1001);
      applyStimulus(4'b1111, 1'b0, 4'b0000);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) midReset();
      applyStimulus(W'($urandom), ($urandom_range(0, 3) == 0), W'($urandom));
    end

    // Let the last expected value be consumed, then confirm nothing is left.
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending required 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
